lms_debug_sequencer: RTL and testbench

Sequences debug operations on the LMS adaptive filter from the control bytes held in the SPI debug register bank. On a load command it freezes adaptation and waits for any in-flight update to finish. It then writes the nine forced weights into the filter's weight port one tap at a time over a valid/ready handshake, and releases the filter. It also produces a fixed-width soft-reset pulse and a status byte that feeds back into the debug register bank's monitor_status probe.

---
 rtl/lms_debug_sequencer.sv | 168 ++++++++++++++++
 tb/tb_lms_debug_sequencer.sv | 250 +++++++++++++++++++++++++
 2 files changed

// File: rtl/lms_debug_sequencer.sv
// lms_debug_sequencer
//   Drives debug operations on the LMS adaptive filter from SPI debug register
//   control bytes. A load command does four things: it freezes adaptation, waits
//   for any in-flight update to finish, streams the forced weights tap by tap
//   over a valid/ready port, and then releases the filter. The block also
//   generates a fixed-length soft-reset pulse and a status byte for the
//   monitor probe.
//
// Ports
//   clk, rst_n        system clock, asynchronous active-low reset
//   sw_reset_cfg      bit0 rising edge -> soft-reset pulse
//   debug_load_cfg    bit0 rising edge -> load; bit1 = hold freeze after load
//   force_w_flat      forced weights, tap k at [k*NB_DATA +: NB_DATA]
//   adapt_busy        filter weight update in progress
//   adapt_freeze      inhibit adaptation
//   wr_valid/wr_ready weight write handshake; wr_idx/wr_data the write payload
//   soft_rst_n        active-low soft reset to the filter
//   load_done         one-cycle pulse when a load completes
//   status            {0.., overrun, done, soft_rst, freeze, busy}
module lms_debug_sequencer #(
    parameter int NB_DATA       = 8,
    parameter int N_TAPS        = 9,
    parameter int NB_IDX        = 4,
    parameter int RST_PULSE_CYC = 16
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic [NB_DATA-1:0]        sw_reset_cfg,
    input  logic [NB_DATA-1:0]        debug_load_cfg,
    input  logic [N_TAPS*NB_DATA-1:0] force_w_flat,
    input  logic                      adapt_busy,
    output logic                      adapt_freeze,
    output logic                      wr_valid,
    input  logic                      wr_ready,
    output logic [NB_IDX-1:0]         wr_idx,
    output logic [NB_DATA-1:0]        wr_data,
    output logic                      soft_rst_n,
    output logic                      load_done,
    output logic [NB_DATA-1:0]        status
);

    localparam int CNT_W = $clog2(RST_PULSE_CYC + 1);

    typedef enum logic [1:0] {S_IDLE, S_FREEZE, S_LOAD, S_DONE} state_t;

    state_t           state;
    logic             rst_cfg_q;
    logic             load_cfg_q;
    logic [CNT_W-1:0] rst_cnt;
    logic [CNT_W-1:0] cnt_nxt;
    logic             done_bit;
    logic             ovr_bit;
    logic             rst_edge;
    logic             load_edge;
    logic             load_drop;
    logic             load_go;
    logic             last_tap;

    // Only bit0 of the reset byte and bits[1:0] of the load byte carry meaning.
    wire unused_cfg = ^{sw_reset_cfg[NB_DATA-1:1], debug_load_cfg[NB_DATA-1:2]};

    assign rst_edge  = sw_reset_cfg[0] & ~rst_cfg_q;
    assign load_edge = debug_load_cfg[0] & ~load_cfg_q;

    // A load edge is dropped (and flagged) if the FSM is busy, a pulse is
    // running, or a reset edge arrives in the same cycle (reset wins).
    assign load_drop = load_edge & (rst_edge | (rst_cnt != '0) | (state != S_IDLE));
    assign load_go   = load_edge & ~load_drop;
    assign last_tap  = (wr_idx == NB_IDX'(N_TAPS - 1));

    always_comb begin
        cnt_nxt = rst_cnt;
        if (rst_edge)
            cnt_nxt = CNT_W'(RST_PULSE_CYC);
        else if (rst_cnt != '0)
            cnt_nxt = rst_cnt - CNT_W'(1);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= S_IDLE;
            rst_cfg_q    <= 1'b0;
            load_cfg_q   <= 1'b0;
            rst_cnt      <= '0;
            done_bit     <= 1'b0;
            ovr_bit      <= 1'b0;
            adapt_freeze <= 1'b0;
            wr_valid     <= 1'b0;
            wr_idx       <= '0;
            load_done    <= 1'b0;
        end else begin
            rst_cfg_q  <= sw_reset_cfg[0];
            load_cfg_q <= debug_load_cfg[0];
            rst_cnt    <= cnt_nxt;
            load_done  <= 1'b0;
            if (load_drop)
                ovr_bit <= 1'b1;

            // Using the next count keeps freeze/IDLE forcing exactly aligned
            // with the cycles where soft_rst_n is low.
            if (cnt_nxt != '0) begin
                state        <= S_IDLE;
                wr_valid     <= 1'b0;
                wr_idx       <= '0;
                adapt_freeze <= 1'b1;
            end else begin
                case (state)
                    S_IDLE: begin
                        if (load_go) begin
                            state        <= S_FREEZE;
                            adapt_freeze <= 1'b1;
                            done_bit     <= 1'b0;
                        end else begin
                            adapt_freeze <= debug_load_cfg[1];
                        end
                    end
                    S_FREEZE: begin
                        adapt_freeze <= 1'b1;
                        if (!adapt_busy) begin
                            state    <= S_LOAD;
                            wr_valid <= 1'b1;
                            wr_idx   <= '0;
                        end
                    end
                    S_LOAD: begin
                        adapt_freeze <= 1'b1;
                        if (wr_valid && wr_ready) begin
                            if (last_tap) begin
                                state     <= S_DONE;
                                wr_valid  <= 1'b0;
                                wr_idx    <= '0;
                                load_done <= 1'b1;
                                done_bit  <= 1'b1;
                            end else begin
                                wr_idx <= wr_idx + NB_IDX'(1);
                            end
                        end
                    end
                    S_DONE: begin
                        state        <= S_IDLE;
                        adapt_freeze <= debug_load_cfg[1];
                    end
                    default: state <= S_IDLE;
                endcase
            end
        end
    end

    // The payload is muxed straight from the register bank by index and held
    // at zero when no write is pending.
    always_comb begin
        wr_data = '0;
        if (wr_valid)
            wr_data = force_w_flat[int'(wr_idx)*NB_DATA +: NB_DATA];
    end

    assign soft_rst_n = (rst_cnt == '0);

    always_comb begin
        status    = '0;
        status[0] = (state != S_IDLE);
        status[1] = adapt_freeze;
        status[2] = ~soft_rst_n;
        status[3] = done_bit;
        status[4] = ovr_bit;
    end

endmodule

// File: tb/tb_lms_debug_sequencer.sv
// Randomized self-checking bench for lms_debug_sequencer. The reference is a
// scoreboard of expected weight writes plus timing rules: a load starts two
// cycles after the trigger plus the busy wait, and it completes one cycle after
// the ninth accepted write.
module tb_lms_debug_sequencer;

    localparam int NB_DATA = 8;
    localparam int N_TAPS  = 9;
    localparam int NB_IDX  = 4;
    localparam int RST_CYC = 16;

    logic                      clk = 1'b0;
    logic                      rst_n;
    logic [NB_DATA-1:0]        sw_reset_cfg;
    logic [NB_DATA-1:0]        debug_load_cfg;
    logic [N_TAPS*NB_DATA-1:0] force_w_flat;
    logic                      adapt_busy;
    logic                      adapt_freeze;
    logic                      wr_valid;
    logic                      wr_ready;
    logic [NB_IDX-1:0]         wr_idx;
    logic [NB_DATA-1:0]        wr_data;
    logic                      soft_rst_n;
    logic                      load_done;
    logic [NB_DATA-1:0]        status;

    int n_vec = 0;
    int n_err = 0;
    bit exp_ovr = 0;
    logic [NB_DATA-1:0] w [N_TAPS];

    lms_debug_sequencer #(
        .NB_DATA(NB_DATA), .N_TAPS(N_TAPS), .NB_IDX(NB_IDX), .RST_PULSE_CYC(RST_CYC)
    ) dut (
        .clk(clk), .rst_n(rst_n), .sw_reset_cfg(sw_reset_cfg),
        .debug_load_cfg(debug_load_cfg), .force_w_flat(force_w_flat),
        .adapt_busy(adapt_busy), .adapt_freeze(adapt_freeze), .wr_valid(wr_valid),
        .wr_ready(wr_ready), .wr_idx(wr_idx), .wr_data(wr_data),
        .soft_rst_n(soft_rst_n), .load_done(load_done), .status(status)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_weights(input bit rnd);
        for (int i = 0; i < N_TAPS; i++) begin
            w[i] = rnd ? NB_DATA'($urandom) : NB_DATA'(8'h10 + i);
            force_w_flat[i*NB_DATA +: NB_DATA] = w[i];
        end
    endtask

    // rmode: 0 ready always, 1 stall first LOAD cycle and at idx 4, 2 random
    task automatic do_load(input bit hold, input int busy_cyc, input int rmode,
                           input int poke_k, input int exp_lat);
        int ew, start, done_k, lat, k;
        bit st0, st4, rdy, exp_v;
        ew = 0; start = 2 + busy_cyc; done_k = -1; lat = -1; st0 = 0; st4 = 0;
        debug_load_cfg = {6'b0, hold, 1'b1};
        adapt_busy = 1'b0;
        wr_ready = 1'b1;
        for (k = 1; k <= 200; k++) begin
            tick();
            adapt_busy = (k <= busy_cyc);
            if (k == 1 || (poke_k != 0 && k == poke_k + 1)) debug_load_cfg[0] = 1'b0;
            if (poke_k != 0 && k == poke_k) begin
                debug_load_cfg[0] = 1'b1;
                exp_ovr = 1;
            end
            exp_v = (k >= start) && (ew < N_TAPS);
            rdy = 1'b1;
            if (rmode == 1 && exp_v && ew == 0 && !st0) begin rdy = 1'b0; st0 = 1; end
            else if (rmode == 1 && exp_v && ew == 4 && !st4) begin rdy = 1'b0; st4 = 1; end
            else if (rmode == 2) rdy = ($urandom_range(0, 3) != 0);
            wr_ready = rdy;
            chk("wr_valid", wr_valid, exp_v);
            chk("load_done", load_done, (done_k == k));
            chk("freeze", adapt_freeze, (done_k < 0 || k <= done_k) ? 1'b1 : hold);
            if (exp_v) begin
                chk("wr_idx", wr_idx, ew);
                chk("wr_data", wr_data, w[ew]);
                if (rdy) begin
                    ew++;
                    if (ew == N_TAPS) done_k = k + 1;
                end
            end
            if (load_done) lat = k;
            if (done_k > 0 && k == done_k + 2) break;
        end
        wr_ready = 1'b1;
        chk("load_timeout", (k <= 200), 1);
        chk("done_cycle", lat, done_k);
        if (exp_lat > 0) chk("done_latency", lat, exp_lat);
        chk("status_after_load", status,
            8'h08 | (exp_ovr ? 8'h10 : 8'h00) | (hold ? 8'h02 : 8'h00));
    endtask

    task automatic do_srst(input int retrig_k);
        int exp_end, low;
        exp_end = (retrig_k > 0) ? retrig_k + RST_CYC : RST_CYC;
        low = 0;
        sw_reset_cfg = 8'h01;
        for (int k = 1; k <= exp_end + 3; k++) begin
            tick();
            if (k == 1 || k == retrig_k + 1) sw_reset_cfg = 8'h00;
            if (retrig_k > 0 && k == retrig_k) sw_reset_cfg = 8'h01;
            chk("soft_rst_n", soft_rst_n, !(k <= exp_end));
            chk("srst_freeze", adapt_freeze, (k <= exp_end));
            chk("status_srst", status[2], (k <= exp_end));
            if (!soft_rst_n) low++;
        end
        chk("srst_len", low, exp_end);
    endtask

    initial begin
        int k;
        bit found;
        rst_n = 1'b0;
        sw_reset_cfg = '0;
        debug_load_cfg = '0;
        force_w_flat = '0;
        adapt_busy = 1'b0;
        wr_ready = 1'b1;
        #13;
        chk("rst_freeze", adapt_freeze, 0);
        chk("rst_valid", wr_valid, 0);
        chk("rst_idx", wr_idx, 0);
        chk("rst_data", wr_data, 0);
        chk("rst_done", load_done, 0);
        chk("rst_status", status, 0);
        chk("rst_srst", soft_rst_n, 1);
        rst_n = 1'b1;
        tick();

        // Basic load and busy/backpressure
        set_weights(0);
        do_load(0, 0, 0, 0, N_TAPS + 2);
        debug_load_cfg = 8'h00; tick();
        set_weights(1);
        do_load(0, 3, 1, 0, N_TAPS + 7);
        debug_load_cfg = 8'h00; tick();

        // Hold
        set_weights(1);
        do_load(1, 0, 0, 0, N_TAPS + 2);
        debug_load_cfg = 8'h02;
        repeat (3) tick();
        chk("hold_keep", adapt_freeze, 1);
        debug_load_cfg = 8'h00;
        tick();
        chk("hold_release", adapt_freeze, 0);

        // Soft reset, then retrigger at pulse cycle 10
        do_srst(0);
        do_srst(10);

        // Reset edge mid-load at idx 5
        set_weights(1);
        debug_load_cfg = 8'h01;
        found = 0;
        for (k = 1; k <= 30; k++) begin
            tick();
            if (k == 1) debug_load_cfg = 8'h00;
            if (wr_valid && wr_idx == 5) begin
                found = 1;
                sw_reset_cfg = 8'h01;
                break;
            end
        end
        chk("idx5_reached", found, 1);
        tick();
        sw_reset_cfg = 8'h00;
        chk("abort_valid", wr_valid, 0);
        chk("abort_idx", wr_idx, 0);
        chk("abort_busy", status[0], 0);
        for (int i = 0; i < RST_CYC + 4; i++) begin
            tick();
            chk("abort_no_done", load_done, 0);
            chk("abort_no_write", wr_valid, 0);
        end
        chk("abort_status", status, 8'h00);

        // Random loads
        for (int r = 0; r < 6; r++) begin
            bit h;
            h = $urandom_range(0, 1);
            set_weights(1);
            do_load(h, $urandom_range(0, 4), 2, 0, 0);
            debug_load_cfg = 8'h00;
            tick();
            chk("rand_release", adapt_freeze, 0);
        end

        // Overrun: second load edge during LOAD
        set_weights(1);
        do_load(0, 0, 0, 5, N_TAPS + 2);
        debug_load_cfg = 8'h00;
        repeat (4) begin
            tick();
            chk("ovr_no_reload", wr_valid, 0);
        end

        // Asynchronous reset mid-load
        debug_load_cfg = 8'h01;
        repeat (3) tick();
        debug_load_cfg = 8'h00;
        #2 rst_n = 1'b0;
        #1;
        chk("async_valid", wr_valid, 0);
        chk("async_freeze", adapt_freeze, 0);
        chk("async_idx", wr_idx, 0);
        chk("async_status", status, 0);
        chk("async_srst", soft_rst_n, 1);
        exp_ovr = 0;
        #1 rst_n = 1'b1;
        tick();

        // Reset and load edges in the same cycle
        sw_reset_cfg = 8'h01;
        debug_load_cfg = 8'h01;
        for (int i = 1; i <= RST_CYC + 4; i++) begin
            tick();
            if (i == 1) begin sw_reset_cfg = 8'h00; debug_load_cfg = 8'h00; end
            chk("coll_no_write", wr_valid, 0);
            chk("coll_srst", soft_rst_n, !(i <= RST_CYC));
        end
        chk("coll_status", status, 8'h10);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL global_timeout got=running exp=finished");
        $fatal(1);
    end

endmodule
